// File: rtl/controller_scan_pkg.sv
// Shared constants and types for the controller scan front end.
package controller_scan_pkg;

  localparam logic [1:0] ADDR_P1_LVL = 2'd0;
  localparam logic [1:0] ADDR_P2_LVL = 2'd1;
  localparam logic [1:0] ADDR_P1_EVT = 2'd2;
  localparam logic [1:0] ADDR_P2_EVT = 2'd3;

  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic {
    R_IDLE,
    R_WAIT
  } rd_state_t;

  // Zero-extend a {down,right,left,up} nibble to a bus word.
  function automatic logic [31:0] pad_word(input logic [3:0] pad);
    return {28'b0, pad[BTN_DOWN], pad[BTN_RIGHT], pad[BTN_LEFT], pad[BTN_UP]};
  endfunction

endpackage

// File: rtl/controller_scan_ctrl_if.sv
// Read request/acknowledge bus between the MMIO decoder and the scan controller.
interface controller_scan_ctrl_if;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/controller_scan_ctrl_debounce_bit.sv
// Per-button debouncer: level filter plus a rising-edge pulse on the filtered level.
// With CTRL_DEBOUNCE_EN undefined the filter collapses to a pass-through.
module debounce_bit #(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
  input  logic tick,
  output logic stable,
  output logic rise
);

`ifdef CTRL_DEBOUNCE_EN
  logic       stable_reg;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_inc;
  logic       accept;

  assign cnt_inc = cnt_reg + 4'd1;
  // A differing level that survives its DB_COUNT-th tick becomes the new stable level.
  assign accept  = tick && (sync != stable_reg) && (cnt_inc == 4'(DB_COUNT));
  assign stable  = stable_reg;
  assign rise    = accept && !stable_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_reg <= 1'b0;
      cnt_reg    <= 4'd0;
    end else if (tick) begin
      if (sync == stable_reg) begin
        cnt_reg <= 4'd0;
      end else if (accept) begin
        stable_reg <= ~stable_reg;
        cnt_reg    <= 4'd0;
      end else begin
        cnt_reg <= cnt_inc;
      end
    end
  end
`else
  localparam int unused_db_count = DB_COUNT;
  logic unused_tick;
  logic prev_reg;

  assign unused_tick = tick;
  assign stable      = sync;
  assign rise        = sync && !prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= sync;
    end
  end
`endif

endmodule

// File: rtl/controller_scan_ctrl.sv
// Controller scan front end: pin sync, debounce, sticky press events, MMIO read FSM.
// Optional feature macro: CTRL_DEBOUNCE_EN (tick-based debounce; pass-through when undefined).
module controller_scan_ctrl
  import controller_scan_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int DB_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [10:1]             JD,
  controller_scan_ctrl_if.slave   bus
);

  logic [7:0]  raw_btn;
  logic [7:0]  sync1_reg;
  logic [7:0]  sync2_reg;
  logic [7:0]  stable_vec;
  logic [7:0]  rise_vec;
  logic [7:0]  evt_reg;
  logic [7:0]  evt_next;
  logic [7:0]  clr_mask;
  logic [31:0] cap_data;
  logic [31:0] rd_data_reg;
  logic        rd_ack_reg;
  logic        capture;
  logic        tick;
  logic [1:0]  unused_jd;
  rd_state_t   state_reg;

  // Bits [3:0] are pad1, [7:4] pad2, each as {down,right,left,up}.
  assign raw_btn   = {JD[7], JD[10], JD[9], JD[8], JD[4], JD[3], JD[2], JD[1]};
  assign unused_jd = JD[6:5];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_btn;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef CTRL_DEBOUNCE_EN
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] tick_cnt_reg;

  assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end
`else
  localparam int unused_tick_div = TICK_DIV;
  assign tick = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_btn
      debounce_bit #(
        .DB_COUNT (DB_COUNT)
      ) u_db (
        .clk    (clk),
        .reset  (reset),
        .sync   (sync2_reg[gi]),
        .tick   (tick),
        .stable (stable_vec[gi]),
        .rise   (rise_vec[gi])
      );
    end
  endgenerate

  assign capture = (state_reg == R_IDLE) && bus.rd_req;

  // Clear-on-read applies first so a same-cycle press still lands in the flag.
  always_comb begin
    clr_mask = '0;
    if (capture) begin
      case (bus.rd_addr)
        ADDR_P1_EVT: clr_mask[3:0] = 4'hF;
        ADDR_P2_EVT: clr_mask[7:4] = 4'hF;
        default:     clr_mask      = '0;
      endcase
    end
    evt_next = (evt_reg & ~clr_mask) | rise_vec;
  end

  always_comb begin
    cap_data = '0;
    case (bus.rd_addr)
      ADDR_P1_LVL: cap_data = pad_word(stable_vec[3:0]);
      ADDR_P2_LVL: cap_data = pad_word(stable_vec[7:4]);
      ADDR_P1_EVT: cap_data = pad_word(evt_reg[3:0]);
      ADDR_P2_EVT: cap_data = pad_word(evt_reg[7:4]);
      default:     cap_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= R_IDLE;
      rd_ack_reg  <= 1'b0;
      rd_data_reg <= '0;
      evt_reg     <= '0;
    end else begin
      evt_reg    <= evt_next;
      rd_ack_reg <= 1'b0;
      case (state_reg)
        R_IDLE: begin
          if (bus.rd_req) begin
            rd_data_reg <= cap_data;
            rd_ack_reg  <= 1'b1;
            state_reg   <= R_WAIT;
          end
        end
        // Wait for the requester to drop rd_req so a held request acks once.
        R_WAIT: begin
          if (!bus.rd_req) begin
            state_reg <= R_IDLE;
          end
        end
        default: state_reg <= R_IDLE;
      endcase
    end
  end

  assign bus.rd_ack  = rd_ack_reg;
  assign bus.rd_data = rd_data_reg;

endmodule

// File: tb/tb_controller_scan_ctrl.sv
// Directed bench for controller_scan_ctrl with TICK_DIV=4, DB_COUNT=3.
module tb_controller_scan_ctrl;
  import controller_scan_pkg::*;

`ifdef CTRL_DEBOUNCE_EN
  localparam bit DEB_ON   = 1'b1;
  localparam int RISE_OFF = 12;
`else
  localparam bit DEB_ON   = 1'b0;
  localparam int RISE_OFF = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:1] jd;
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt;

  controller_scan_ctrl_if bus ();

  controller_scan_ctrl #(
    .TICK_DIV (4),
    .DB_COUNT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .JD    (jd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus.rd_addr = addr;
    bus.rd_req  = 1'b1;
    step();
    check({tag, "_ack"}, {31'b0, bus.rd_ack}, 32'd1);
    check({tag, "_data"}, bus.rd_data, exp);
    $display("read addr=%0d data=%h exp=%h (%s)", addr, bus.rd_data, exp, tag);
    bus.rd_req = 1'b0;
    step();
    check({tag, "_ackdrop"}, {31'b0, bus.rd_ack}, 32'd0);
  endtask

  initial begin
    jd          = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = 2'd0;
    reset       = 1'b1;

    // Reset and idle read
    do_reset();
    check("rst_ack", {31'b0, bus.rd_ack}, 32'd0);
    check("rst_data", bus.rd_data, 32'd0);
    do_read(ADDR_P1_LVL, 32'h0, "idle_lvl");

    // Clean press on pad1 up
    jd[1] = 1'b1;
    steps(20);
    do_read(ADDR_P1_LVL, 32'h1, "press_lvl");
    do_read(ADDR_P1_EVT, 32'h1, "press_evt");
    do_read(ADDR_P1_EVT, 32'h0, "press_evt_clr");

    // Bounce on pad2 right: 5-cycle half periods never survive three ticks
    for (int h = 0; h < 8; h++) begin
      jd[10] = (h % 2 == 0);
      steps(5);
    end
    jd[10] = 1'b0;
    steps(5);
    do_read(ADDR_P2_LVL, 32'h0, "bounce_lvl");
    do_read(ADDR_P2_EVT, DEB_ON ? 32'h0 : 32'h4, "bounce_evt");

    // Held request acks exactly once
    jd[8] = 1'b1;
    steps(20);
    bus.rd_addr = ADDR_P2_LVL;
    bus.rd_req  = 1'b1;
    ack_cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rd_ack) ack_cnt++;
    end
    check("held_acks", ack_cnt, 32'd1);
    check("held_data", bus.rd_data, 32'h1);
    $display("held read acks=%0d data=%h", ack_cnt, bus.rd_data);
    bus.rd_req = 1'b0;
    step();
    check("held_drop", {31'b0, bus.rd_ack}, 32'd0);
    bus.rd_req = 1'b1;
    step();
    check("held_reack", {31'b0, bus.rd_ack}, 32'd1);
    bus.rd_req = 1'b0;
    step();

    // Set/clear collision: pad1 down rises on the capture edge of an addr 2 read
    jd = '0;
    do_reset();
    jd[4] = 1'b1;
    steps(RISE_OFF - 1);
    bus.rd_addr = ADDR_P1_EVT;
    bus.rd_req  = 1'b1;
    step();
    check("coll_ack", {31'b0, bus.rd_ack}, 32'd1);
    check("coll_data", bus.rd_data, 32'h0);
    $display("collision read data=%h", bus.rd_data);
    bus.rd_req = 1'b0;
    step();
    do_read(ADDR_P1_EVT, 32'h8, "coll_next");

    // Reset mid-read discards a pending event
    jd = '0;
    jd[1] = 1'b1;
    steps(20);
    bus.rd_addr = ADDR_P1_LVL;
    bus.rd_req  = 1'b1;
    step();
    check("mid_ack", {31'b0, bus.rd_ack}, 32'd1);
    jd    = '0;
    reset = 1'b1;
    step();
    check("mid_ackdrop", {31'b0, bus.rd_ack}, 32'd0);
    check("mid_data", bus.rd_data, 32'h0);
    $display("reset mid-read ack=%0d data=%h", bus.rd_ack, bus.rd_data);
    reset      = 1'b0;
    bus.rd_req = 1'b0;
    steps(5);
    do_read(ADDR_P1_EVT, 32'h0, "mid_evt_lost");

    // Short release of pad2 up: only the pass-through build sees a second press
    jd[8] = 1'b1;
    steps(20);
    do_read(ADDR_P2_EVT, 32'h1, "rel_evt1");
    jd[8] = 1'b0;
    step();
    jd[8] = 1'b1;
    steps(20);
    do_read(ADDR_P2_EVT, DEB_ON ? 32'h0 : 32'h1, "rel_evt2");
    do_read(ADDR_P2_LVL, 32'h1, "rel_lvl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_scan_ctrl.md
# controller_scan_ctrl

Sequencing front end for the two 4-button game controllers on the JD header. It synchronizes the raw pins and debounces each button on a programmable sample tick. It records rising-edge press events in clear-on-read sticky registers. It serves processor reads from the MMIO decoder through a req/ack handshake, so the CPU sees stable levels and never misses a short press between polls.

## Interface
Parameters:
- TICK_DIV, 100000: clk cycles per sample tick (1 kHz at 100 MHz); legal range ≥2.
- DB_COUNT, 4: consecutive ticks a new level must persist before it is accepted; legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- JD  in  10 [10:1]  raw controller pins.
  - Pad1 is {down,right,left,up} = {JD[4],JD[3],JD[2],JD[1]}.
  - Pad2 is {down,right,left,up} = {JD[7],JD[10],JD[9],JD[8]}.
- rd_req  in  1  read request, level; held by the requester until rd_ack.
- rd_addr  in  2  register select: 0 pad1 level, 1 pad2 level, 2 pad1 events, 3 pad2 events.
- rd_ack  out  1  one-cycle pulse; rd_data is valid in the same cycle.
- rd_data  out  32  {28'b0, down, right, left, up} for the selected register.

## Operation
- Synchronizer: 2-FF on all 8 button bits.
- Tick counter: runs 0..TICK_DIV-1. tick is asserted in the cycle where count = TICK_DIV-1, then the counter wraps to 0.
- Debounce, per bit, evaluated on tick only:
  - If sync ≠ stable, increment cnt. When cnt reaches DB_COUNT, toggle stable and clear cnt.
  - If sync = stable, clear cnt. A bounce therefore restarts the count.
- Events: a stable 0→1 transition sets that bit's sticky event flag. 1→0 transitions set nothing.
- Read FSM states:
  - R_IDLE: when rd_req is high, capture the selected register into rd_data, pulse rd_ack, and go to R_WAIT.
  - R_WAIT: rd_ack is low. Return to R_IDLE when rd_req is low.
  - Each request is served exactly once, including when rd_req is held high.
- Clear-on-read: capturing address 2 or 3 clears that pad's event flags in the capture cycle.
  - If a new event sets a flag in the same cycle, set wins: the flag stays 1.
  - The captured data carries the pre-set value.
- Level reads (addresses 0/1) have no side effects.
- rd_addr is sampled only in the R_IDLE capture cycle.
- rd_data holds its last captured value between reads.

## Timing
- Reset values: rd_ack 0, rd_data 0, FSM R_IDLE, tick counter 0, all stable/cnt/event/sync bits 0.
- Read latency: rd_req first high at cycle N gives rd_ack=1 with rd_data valid at cycle N+1. Minimum spacing between acks is 3 cycles (ack, rd_req low seen, new capture).
- Pin-to-stable latency: 2 cycles of synchronization, then DB_COUNT ticks. Worst case is 2 + DB_COUNT·TICK_DIV cycles.
- An event flag is set in the same cycle stable rises. A read captured in the following cycle or later returns it.
- Reset mid-read: rd_ack drops the next cycle, the FSM returns to R_IDLE, and all pending events are lost.

## Configuration
- CTRL_DEBOUNCE_EN defined:
  - The debounce counters and tick counter are built as described above.
- CTRL_DEBOUNCE_EN undefined:
  - No tick counter or cnt registers are built; TICK_DIV and DB_COUNT are ignored.
  - stable = sync every cycle, with 2-cycle pin latency.
  - Event and read behaviour are unchanged.

## Structure
- Package controller_scan_pkg:
  - Register address constants ADDR_P1_LVL=0, ADDR_P2_LVL=1, ADDR_P1_EVT=2, ADDR_P2_EVT=3.
  - Button bit indices BTN_UP=0, BTN_LEFT=1, BTN_RIGHT=2, BTN_DOWN=3.
  - Read FSM state enum {R_IDLE, R_WAIT}.
- Sub-module debounce_bit: one instance per button (8 total). Inputs are clk, reset, sync, tick. Outputs are stable and a rise pulse. The CTRL_DEBOUNCE_EN choice lives inside this module.

## Test plan
All scenarios use TICK_DIV=4 and DB_COUNT=3 with CTRL_DEBOUNCE_EN defined unless noted.
- Reset/idle: assert reset 2 cycles, then read addr 0 → rd_ack one cycle after rd_req; rd_data=32'h0.
- Clean press: JD[1]=1 held for 20 cycles → read addr 0 returns 32'h1. Read addr 2 returns 32'h1. A second read of addr 2 returns 32'h0.
- Bounce rejection: JD[10] toggles every 5 cycles for 40 cycles → pad2 stable stays 0; read addr 3 returns 32'h0.
- Held request: rd_req held high for 10 cycles at addr 1 → exactly one rd_ack pulse. A new ack comes only after rd_req drops and rises again.
- Set/clear collision: arrange for JD[4] stable to rise in the exact capture cycle of an addr 2 read → rd_data=32'h0 for that read; the next addr 2 read returns 32'h8.
- Macro off (CTRL_DEBOUNCE_EN undefined): JD[8]=1 at cycle 0 → pad2 level reads 32'h1 from cycle 2 onward. A 1-cycle release of JD[8] produces a second event on the next rise.
